// File: rtl/seg2hex.sv
// Seven-segment scan to hex frame decoder: debounces {an_in,seg_in}, decodes digits, emits 16-bit frames.
// Optional macro SEG2HEX_ERR_EN enables sticky per-digit invalid-pattern flags on err.
module seg2hex #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  an_in,
  output logic [15:0] hex_out,
  output logic        frame_valid,
  output logic [3:0]  err
);

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_e;

  localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);
  localparam logic [3:0] STABLE_M1 = 4'(STABLE_CYCLES - 1);

  function automatic logic [3:0] seg_nibble(input logic [6:0] seg);
    case (seg)
      7'h3F: return 4'h0;
      7'h06: return 4'h1;
      7'h5B: return 4'h2;
      7'h4F: return 4'h3;
      7'h66: return 4'h4;
      7'h6D: return 4'h5;
      7'h7D: return 4'h6;
      7'h07: return 4'h7;
      7'h7F: return 4'h8;
      7'h6F: return 4'h9;
      7'h77: return 4'hA;
      7'h7C: return 4'hB;
      7'h39: return 4'hC;
      7'h5E: return 4'hD;
      7'h79: return 4'hE;
      7'h71: return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

`ifdef SEG2HEX_ERR_EN
  function automatic logic seg_valid(input logic [6:0] seg);
    case (seg)
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
`endif

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] digit_index(input logic [3:0] v);
    case (v)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  logic [10:0] pair;
  logic [10:0] pair_prev_q, pair_prev_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] cap_q, cap_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] hex_q, hex_d;
  state_e      state_q, state_d;
  logic        accept;
  logic        take;
  logic        frame_done;
  logic [3:0]  mask_next;
  logic [1:0]  dig;

  assign pair = {an_in, seg_in};

  // Stability tracking: a run is accepted once, on the edge the counter reaches STABLE_CYCLES
  always_comb begin
    pair_prev_d = pair;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    if (pair != pair_prev_q) begin
      cnt_d = 4'd1;
    end else begin
      if (cnt_q != STABLE_N) begin
        cnt_d = cnt_q + 4'd1;
      end
      accept = (cnt_q == STABLE_M1) && is_onehot(an_in);
    end
  end

`ifdef SEG2HEX_ERR_EN
  logic [3:0] err_q, err_d;

  always_comb begin
    take  = accept && seg_valid(seg_in);
    err_d = err_q;
    if (accept && !seg_valid(seg_in)) begin
      err_d = err_q | an_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 4'd0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign take = accept;
  assign err  = 4'd0;
`endif

  // Capture: the digit accepted on the completing edge still lands in the emitted frame
  always_comb begin
    dig       = digit_index(an_in);
    cap_d     = cap_q;
    mask_next = mask_q;
    if (take) begin
      cap_d[{dig, 2'b00} +: 4] = seg_nibble(seg_in);
      mask_next                = mask_q | an_in;
    end
    frame_done = (mask_next == 4'hF);
    mask_d     = frame_done ? 4'd0 : mask_next;
    hex_d      = frame_done ? cap_d : hex_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pair_prev_q <= 11'd0;
      cnt_q       <= 4'd0;
      cap_q       <= 16'd0;
      mask_q      <= 4'd0;
      hex_q       <= 16'd0;
    end else begin
      pair_prev_q <= pair_prev_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      mask_q      <= mask_d;
      hex_q       <= hex_d;
    end
  end

  // Frame FSM: EMIT lasts exactly the one cycle after the mask completes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = frame_done ? EMIT : COLLECT;
  end

  always_comb begin
    frame_valid = (state_q == EMIT);
  end

  assign hex_out = hex_q;

endmodule

// File: tb/tb_seg2hex.sv
// Directed bench for seg2hex: an abstract run-length/digit model checked every cycle plus literal frame values.
module tb_seg2hex;

  localparam int STABLE = 4;
  localparam bit [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] hex_out;
  logic        frame_valid;
  logic [3:0]  err;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  bit started = 0;

  seg2hex #(.STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in),
    .hex_out(hex_out), .frame_valid(frame_valid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int seg_value(input bit [6:0] s);
    for (int i = 0; i < 16; i++) if (SEG_TAB[i] == s) return i;
    return -1;
  endfunction

  // Model: run length of the current pair, digits held per position, latched frame.
  bit [10:0] m_prev;
  int        m_run;
  bit [3:0]  m_have;
  bit [3:0]  m_cap [4];
  bit [15:0] m_hex;
  bit        m_fv;
  bit [3:0]  m_err;

  always @(posedge clk) begin
    bit [10:0] p;
    int k, v;
    p = {an_in, seg_in};
    if (rst) begin
      m_prev = '0; m_run = 0; m_have = '0; m_hex = '0; m_fv = 0; m_err = '0;
      for (int i = 0; i < 4; i++) m_cap[i] = '0;
    end else begin
      m_fv = 0;
      if (p == m_prev) m_run++;
      else begin
        m_run = 1;
        m_prev = p;
      end
      if (m_run == STABLE && $countones(an_in) == 1) begin
        k = 0;
        for (int i = 0; i < 4; i++) if (an_in[i]) k = i;
        v = seg_value(seg_in);
`ifdef SEG2HEX_ERR_EN
        if (v < 0) m_err[k] = 1'b1;
        else begin
          m_cap[k] = 4'(v);
          m_have[k] = 1'b1;
        end
`else
        m_cap[k] = (v < 0) ? 4'd0 : 4'(v);
        m_have[k] = 1'b1;
`endif
        if (m_have == 4'hF) begin
          m_hex = {m_cap[3], m_cap[2], m_cap[1], m_cap[0]};
          m_fv = 1;
          m_have = '0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("hex_out", 32'(hex_out), 32'(m_hex));
      check("frame_valid", 32'(frame_valid), 32'(m_fv));
      check("err", 32'(err), 32'(m_err));
      if (frame_valid === 1'b1) pulses++;
    end
  end

  task automatic send(input logic [3:0] a, input logic [6:0] s, input int n);
    @(negedge clk);
    an_in = a;
    seg_in = s;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic idle(input int n);
    send(4'b0000, 7'h00, n);
  endtask

  int p0;

  initial begin
    rst = 1'b1; an_in = '0; seg_in = '0;
    @(negedge clk);
    started = 1;
    check("reset hex_out", 32'(hex_out), 32'h0);
    check("reset frame_valid", 32'(frame_valid), 32'h0);
    check("reset err", 32'(err), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Basic frame 3210
    p0 = pulses;
    send(4'b0001, 7'h3F, 4); send(4'b0010, 7'h06, 4);
    send(4'b0100, 7'h5B, 4); send(4'b1000, 7'h4F, 4);
    idle(4);
    check("frame 3210", 32'(hex_out), 32'h3210);
    check("frame 3210 pulses", 32'(pulses - p0), 32'd1);

    // Short run of 7F on digit 0 must not count; digits 1..3 alone must not complete
    p0 = pulses;
    send(4'b0001, 7'h7F, 3);
    send(4'b0010, 7'h06, 4); send(4'b0100, 7'h5B, 4); send(4'b1000, 7'h4F, 4);
    idle(4);
    check("short run no frame", 32'(pulses - p0), 32'd0);
    check("short run hex held", 32'(hex_out), 32'h3210);
    send(4'b0001, 7'h66, 4);
    idle(4);
    check("frame 3214", 32'(hex_out), 32'h3214);
    check("frame 3214 pulses", 32'(pulses - p0), 32'd1);

    // Overwrite of digit 1 before completion
    p0 = pulses;
    send(4'b0001, 7'h71, 4); send(4'b0010, 7'h79, 4); send(4'b0100, 7'h5E, 4);
    send(4'b0010, 7'h5B, 4); send(4'b1000, 7'h39, 4);
    idle(4);
    check("frame CD2F", 32'(hex_out), 32'hCD2F);
    check("frame CD2F pulses", 32'(pulses - p0), 32'd1);

    // Non-one-hot enable held long is ignored
    p0 = pulses;
    send(4'b0011, 7'h3F, 20);
    send(4'b0001, 7'h7D, 4); send(4'b0010, 7'h07, 4);
    send(4'b0100, 7'h7F, 4); send(4'b1000, 7'h6F, 4);
    idle(4);
    check("frame 9876", 32'(hex_out), 32'h9876);
    check("frame 9876 pulses", 32'(pulses - p0), 32'd1);

    // Invalid pattern on digit 2
    p0 = pulses;
    send(4'b0100, 7'h00, 4);
    idle(2);
`ifdef SEG2HEX_ERR_EN
    check("invalid sets err", 32'(err), 32'h4);
    send(4'b0001, 7'h3F, 4); send(4'b0010, 7'h06, 4); send(4'b1000, 7'h4F, 4);
    idle(3);
    check("invalid not captured", 32'(pulses - p0), 32'd0);
    send(4'b0100, 7'h5B, 4);
    idle(4);
    check("frame after invalid", 32'(hex_out), 32'h3210);
`else
    check("invalid no err", 32'(err), 32'h0);
    send(4'b0001, 7'h3F, 4); send(4'b0010, 7'h06, 4); send(4'b1000, 7'h4F, 4);
    idle(4);
    check("frame invalid as 0", 32'(hex_out), 32'h3010);
`endif
    check("invalid scenario pulses", 32'(pulses - p0), 32'd1);

    // Reset mid-frame discards partial digits
    send(4'b0001, 7'h77, 4); send(4'b0010, 7'h7C, 4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset hex_out", 32'(hex_out), 32'h0);
    check("midreset frame_valid", 32'(frame_valid), 32'h0);
    check("midreset err", 32'(err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    p0 = pulses;
    send(4'b0100, 7'h39, 4); send(4'b1000, 7'h5E, 4);
    idle(3);
    check("partial discarded", 32'(pulses - p0), 32'd0);
    send(4'b0001, 7'h77, 4); send(4'b0010, 7'h7C, 4);
    idle(4);
    check("frame DCBA", 32'(hex_out), 32'hDCBA);
    check("frame DCBA pulses", 32'(pulses - p0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
